ps2_led_ctrl: RTL and testbench

Host-side command sequencer that keeps the keyboard's Caps/Num/Scroll LEDs in step with the lock state tracked by the RX path. It sits between the byte receiver and the scancode decoder. It issues the PS/2 "Set LEDs" sequence (0xED, then the LED byte) through a byte transmitter, retrying on failure. While a command is in flight it consumes the keyboard's 0xFA/0xFE responses so they never reach the scancode decoder; all other bytes pass through.

---
 rtl/ps2_led_ctrl_if.sv | 33 +++
 rtl/ps2_led_ctrl.sv | 125 ++++++++++++
 tb/tb_ps2_led_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_led_ctrl_if.sv
// Signal bundle between the LED command sequencer and its byte RX/TX neighbours.
// The master side is the sequencer; the slave side is the surrounding logic or a bench.
interface ps2_led_ctrl_if;
    logic       i_byte_en;
    logic [7:0] i_byte;
    logic       i_capslock;
    logic       i_numlock;
    logic       i_scrolllock;
    logic       i_tx_done;
    logic       i_tx_err;
    logic       o_byte_en;
    logic [7:0] o_byte;
    logic       o_tx_req;
    logic [7:0] o_tx_byte;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [2:0] o_led_state;
    // Debug view of the FSM state: 0 IDLE, 1 SEND_CMD, 2 WAIT_ACK1, 3 SEND_LED, 4 WAIT_ACK2
    logic [2:0] o_state;

    modport master (
        input  i_byte_en, i_byte, i_capslock, i_numlock, i_scrolllock, i_tx_done, i_tx_err,
        output o_byte_en, o_byte, o_tx_req, o_tx_byte, o_busy, o_done, o_err, o_led_state,
               o_state
    );

    modport slave (
        output i_byte_en, i_byte, i_capslock, i_numlock, i_scrolllock, i_tx_done, i_tx_err,
        input  o_byte_en, o_byte, o_tx_req, o_tx_byte, o_busy, o_done, o_err, o_led_state,
               o_state
    );
endinterface

// File: rtl/ps2_led_ctrl.sv
// Keeps keyboard LEDs in step with the lock state: sends 0xED + LED byte with retries,
// and hides the keyboard's 0xFA/0xFE answers from the scancode path while waiting for them.
module ps2_led_ctrl #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic           clk,
    input  logic           i_sclr,
    ps2_led_ctrl_if.master bus
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        WAIT_ACK1 = 3'd2,
        SEND_LED  = 3'd3,
        WAIT_ACK2 = 3'd4
    } state_t;

    state_t        r_state;
    logic [2:0]    r_snap;
    logic [2:0]    r_last;
    logic [RW-1:0] r_retry;
    logic [TW-1:0] r_tmo;
    logic          r_done;
    logic          r_err;

    logic [2:0] w_req;
    logic       w_pending;
    logic       w_ack;
    logic       w_nak;
    logic       w_in_wait;
    logic       w_in_send;
    logic       w_tmo_hit;
    logic       w_fail;

    assign w_req     = {bus.i_capslock, bus.i_numlock, bus.i_scrolllock};
    assign w_pending = (w_req != r_last);
    assign w_ack     = bus.i_byte_en && (bus.i_byte == 8'hFA);
    assign w_nak     = bus.i_byte_en && (bus.i_byte == 8'hFE);
    assign w_in_wait = (r_state == WAIT_ACK1) || (r_state == WAIT_ACK2);
    assign w_in_send = (r_state == SEND_CMD) || (r_state == SEND_LED);
    assign w_tmo_hit = (r_tmo == TMO_LAST);
    // An accepting 0xFA beats a timeout in the same cycle; err beats done while sending.
    assign w_fail    = (w_in_send && bus.i_tx_err) ||
                       (w_in_wait && !w_ack && (w_nak || w_tmo_hit));

    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_last  <= '0;
            r_retry <= '0;
            r_tmo   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_fail) begin
                // Giving up still commits the snapshot so a dead keyboard cannot cause endless retries.
                if (r_retry == RETRY_LAST) begin
                    r_err   <= 1'b1;
                    r_last  <= r_snap;
                    r_state <= IDLE;
                end else begin
                    r_retry <= r_retry + 1'b1;
                    r_state <= SEND_CMD;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_pending) begin
                            r_snap  <= w_req;
                            r_retry <= '0;
                            r_state <= SEND_CMD;
                        end
                    end
                    SEND_CMD: begin
                        if (bus.i_tx_done) begin
                            r_tmo   <= '0;
                            r_state <= WAIT_ACK1;
                        end
                    end
                    WAIT_ACK1: begin
                        if (w_ack) r_state <= SEND_LED;
                        else       r_tmo   <= r_tmo + 1'b1;
                    end
                    SEND_LED: begin
                        if (bus.i_tx_done) begin
                            r_tmo   <= '0;
                            r_state <= WAIT_ACK2;
                        end
                    end
                    WAIT_ACK2: begin
                        if (w_ack) begin
                            r_last  <= r_snap;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_byte      = bus.i_byte;
    assign bus.o_byte_en   = bus.i_byte_en &&
                             !(w_in_wait && ((bus.i_byte == 8'hFA) || (bus.i_byte == 8'hFE)));
    assign bus.o_tx_req    = w_in_send;
    assign bus.o_tx_byte   = (r_state == SEND_CMD) ? 8'hED :
                             (r_state == SEND_LED) ? {5'b0, r_snap} : 8'h00;
    assign bus.o_busy      = (r_state != IDLE);
    assign bus.o_done      = r_done;
    assign bus.o_err       = r_err;
    assign bus.o_led_state = r_last;
    assign bus.o_state     = r_state;
endmodule

// File: tb/tb_ps2_led_ctrl.sv
// Directed bench for ps2_led_ctrl: instance A (16-cycle timeout, 3 retries) covers the
// protocol scenarios; instance B (16-cycle timeout, 1 retry) covers the give-up path.
module tb_ps2_led_ctrl;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    ps2_led_ctrl_if bus_a ();
    ps2_led_ctrl_if bus_b ();

    ps2_led_ctrl #(.TIMEOUT_CYCLES(16), .MAX_RETRY(3)) u_dut_a (
        .clk    (clk),
        .i_sclr (rst_a),
        .bus    (bus_a)
    );

    ps2_led_ctrl #(.TIMEOUT_CYCLES(16), .MAX_RETRY(1)) u_dut_b (
        .clk    (clk),
        .i_sclr (rst_b),
        .bus    (bus_b)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int done_cnt_a = 0;
    int err_cnt_a = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (bus_a.o_done) done_cnt_a++;
        if (bus_a.o_err)  err_cnt_a++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_req_a(input logic c, input logic n, input logic s);
        bus_a.i_capslock   = c;
        bus_a.i_numlock    = n;
        bus_a.i_scrolllock = s;
    endtask

    task automatic send_a(input string tag, input logic [7:0] b, input logic exp_fwd);
        bus_a.i_byte    = b;
        bus_a.i_byte_en = 1'b1;
        #1;
        check({tag, " fwd"}, bus_a.o_byte_en, exp_fwd);
        check({tag, " byte"}, bus_a.o_byte, b);
        tick();
        bus_a.i_byte_en = 1'b0;
    endtask

    task automatic tx_a(input string tag);
        int n;
        logic [7:0] e;
        n = 0;
        while (!bus_a.o_tx_req && n < 50) begin
            tick();
            n++;
        end
        check({tag, " req"}, bus_a.o_tx_req, 1);
        e = 8'hxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check({tag, " txbyte"}, bus_a.o_tx_byte, e);
        bus_a.i_tx_done = 1'b1;
        tick();
        bus_a.i_tx_done = 1'b0;
    endtask

    initial begin
        int n;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.i_byte_en = 1'b0; bus_a.i_byte = 8'h00; bus_a.i_tx_done = 1'b0; bus_a.i_tx_err = 1'b0;
        bus_b.i_byte_en = 1'b0; bus_b.i_byte = 8'h00; bus_b.i_tx_done = 1'b0; bus_b.i_tx_err = 1'b0;
        set_req_a(0, 0, 0);
        bus_b.i_capslock = 1'b0; bus_b.i_numlock = 1'b0; bus_b.i_scrolllock = 1'b0;
        repeat (3) tick();

        check("rst busy", bus_a.o_busy, 0);
        check("rst tx_req", bus_a.o_tx_req, 0);
        check("rst tx_byte", bus_a.o_tx_byte, 8'h00);
        check("rst led", bus_a.o_led_state, 3'b000);
        check("rst done", bus_a.o_done, 0);
        check("rst err", bus_a.o_err, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // Basic update: caps on -> ED, 04
        set_req_a(1, 0, 0);
        tick();
        check("t1 latency req", bus_a.o_tx_req, 1);
        check("t1 latency byte", bus_a.o_tx_byte, 8'hED);
        exp_q.push_back(8'hED);
        tx_a("t1 cmd");
        send_a("t1 ack1", 8'hFA, 0);
        exp_q.push_back(8'h04);
        tx_a("t1 led");
        send_a("t1 ack2", 8'hFA, 0);
        check("t1 done", bus_a.o_done, 1);
        check("t1 led_state", bus_a.o_led_state, 3'b100);
        check("t1 busy", bus_a.o_busy, 0);
        tick();
        check("t1 done pulse", bus_a.o_done, 0);
        check("t1 idle", bus_a.o_busy, 0);

        // Unrelated byte during WAIT_ACK1 passes through
        set_req_a(1, 0, 1);
        exp_q.push_back(8'hED);
        tx_a("t2 cmd");
        send_a("t2 scancode", 8'h1C, 1);
        check("t2 state", bus_a.o_state, 3'd2);
        check("t2 tx_req", bus_a.o_tx_req, 0);
        send_a("t2 ack1", 8'hFA, 0);
        exp_q.push_back(8'h05);
        tx_a("t2 led");
        send_a("t2 ack2", 8'hFA, 0);
        check("t2 led_state", bus_a.o_led_state, 3'b101);
        send_a("t2 idle FA", 8'hFA, 1);
        check("t2 idle busy", bus_a.o_busy, 0);

        // NAK on LED byte twice, then ACK
        set_req_a(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'hED);
            tx_a("t3 cmd");
            send_a("t3 ack1", 8'hFA, 0);
            exp_q.push_back(8'h01);
            tx_a("t3 led");
            send_a("t3 ack2", (i < 2) ? 8'hFE : 8'hFA, 0);
        end
        check("t3 done", bus_a.o_done, 1);
        check("t3 led_state", bus_a.o_led_state, 3'b001);

        // Async reset while sending the LED byte
        set_req_a(0, 1, 0);
        exp_q.push_back(8'hED);
        tx_a("t4 cmd");
        send_a("t4 ack1", 8'hFA, 0);
        check("t4 sendled req", bus_a.o_tx_req, 1);
        check("t4 sendled byte", bus_a.o_tx_byte, 8'h02);
        rst_a = 1'b1;
        #1;
        check("t4 rst req", bus_a.o_tx_req, 0);
        check("t4 rst led", bus_a.o_led_state, 3'b000);
        tick();
        rst_a = 1'b0;
        tick();
        check("t4 restart req", bus_a.o_tx_req, 1);
        check("t4 restart byte", bus_a.o_tx_byte, 8'hED);
        exp_q.push_back(8'hED);
        tx_a("t4 cmd2");
        send_a("t4 ack1b", 8'hFA, 0);
        exp_q.push_back(8'h02);
        tx_a("t4 led2");
        send_a("t4 ack2", 8'hFA, 0);
        check("t4 led_state", bus_a.o_led_state, 3'b010);

        // Request change during WAIT_ACK2
        set_req_a(1, 0, 0);
        exp_q.push_back(8'hED);
        tx_a("t5 cmd");
        send_a("t5 ack1", 8'hFA, 0);
        exp_q.push_back(8'h04);
        tx_a("t5 led");
        set_req_a(1, 1, 0);
        send_a("t5 ack2", 8'hFA, 0);
        check("t5 done", bus_a.o_done, 1);
        check("t5 led_state old", bus_a.o_led_state, 3'b100);
        check("t5 gap req", bus_a.o_tx_req, 0);
        tick();
        check("t5 next req", bus_a.o_tx_req, 1);
        check("t5 next byte", bus_a.o_tx_byte, 8'hED);
        exp_q.push_back(8'hED);
        tx_a("t5 cmd2");
        send_a("t5 ack1b", 8'hFA, 0);
        exp_q.push_back(8'h06);
        tx_a("t5 led2");
        send_a("t5 ack2b", 8'hFA, 0);
        check("t5 led_state new", bus_a.o_led_state, 3'b110);

        // Simultaneous done and err: err wins, retry from ED
        set_req_a(0, 0, 0);
        tick();
        check("t6 req", bus_a.o_tx_req, 1);
        bus_a.i_tx_done = 1'b1;
        bus_a.i_tx_err  = 1'b1;
        tick();
        bus_a.i_tx_done = 1'b0;
        bus_a.i_tx_err  = 1'b0;
        check("t6 state", bus_a.o_state, 3'd1);
        check("t6 byte", bus_a.o_tx_byte, 8'hED);
        exp_q.push_back(8'hED);
        tx_a("t6 cmd");
        send_a("t6 ack1", 8'hFA, 0);
        exp_q.push_back(8'h00);
        tx_a("t6 led");
        send_a("t6 ack2", 8'hFA, 0);
        check("t6 led_state", bus_a.o_led_state, 3'b000);
        tick();

        // Instance B: no ACK ever, one retry, then give up
        bus_b.i_capslock = 1'b1;
        tick();
        for (int att = 0; att < 2; att++) begin
            check("t7 req", bus_b.o_tx_req, 1);
            check("t7 byte", bus_b.o_tx_byte, 8'hED);
            bus_b.i_tx_done = 1'b1;
            tick();
            bus_b.i_tx_done = 1'b0;
            n = 0;
            while (!bus_b.o_tx_req && bus_b.o_busy && n < 100) begin
                tick();
                n++;
            end
            check("t7 wait cycles", n, 16);
        end
        check("t7 err", bus_b.o_err, 1);
        check("t7 busy", bus_b.o_busy, 0);
        check("t7 led_state", bus_b.o_led_state, 3'b100);
        tick();
        check("t7 err pulse", bus_b.o_err, 0);
        check("t7 stays idle", bus_b.o_state, 3'd0);
        tick();
        check("t7 no resend", bus_b.o_tx_req, 0);

        check("sb queue empty", exp_q.size(), 0);
        check("a done count", done_cnt_a, 7);
        check("a err count", err_cnt_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
